// File: rtl/transit_stim_seq.sv
// Stimulus sequencer for the transport/bus/train checker: replays a latched
// testcase table one signal update per STEP_CYCLES clocks, then idles a tail and pulses done.
module transit_stim_seq #(
    parameter int unsigned NUM_TC      = 6,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned TAIL_CYCLES = 3,
    parameter int unsigned IDX_W       = (NUM_TC > 1) ? $clog2(NUM_TC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    input  logic [3*NUM_TC-1:0]   tc_table,
    output logic                  transport,
    output logic                  bus,
    output logic                  train,
    output logic [IDX_W-1:0]      tc_idx,
    output logic [1:0]            phase,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned TAIL_W = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
    localparam int unsigned TBL_W  = 3 * NUM_TC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TBL_W-1:0]    tbl_q, tbl_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TAIL_W-1:0]   tail_q, tail_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          phase_q, phase_d;
    logic [2:0]          stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [2:0]          cur_tc;

    // Testcase word selected by the current index, {transport, bus, train}
    always_comb begin
        cur_tc = 3'b000;
        for (int unsigned k = 0; k < NUM_TC; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_tc = tbl_q[3*k +: 3];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tbl_q   <= '0;
            step_q  <= '0;
            tail_q  <= '0;
            idx_q   <= '0;
            phase_q <= 2'd0;
            stim_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            step_q  <= step_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        step_d  = step_q;
        tail_d  = tail_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tbl_d   = tc_table;
                    stim_d  = 3'b000;
                    idx_d   = '0;
                    phase_d = 2'd0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!hold) begin
                    if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
                        step_d = '0;
                        // Exactly one stimulus bit moves per update edge
                        case (phase_q)
                            2'd0:    stim_d[2] = cur_tc[2];
                            2'd1:    stim_d[1] = cur_tc[1];
                            default: stim_d[0] = cur_tc[0];
                        endcase
                        if (phase_q == 2'd2) begin
                            if (idx_q == IDX_W'(NUM_TC - 1)) begin
                                tail_d  = '0;
                                state_d = S_TAIL;
                            end else begin
                                idx_d   = IDX_W'(idx_q + 1'b1);
                                phase_d = 2'd0;
                            end
                        end else begin
                            phase_d = 2'(phase_q + 2'd1);
                        end
                    end else begin
                        step_d = STEP_W'(step_q + 1'b1);
                    end
                end
            end

            S_TAIL: begin
                if (!hold) begin
                    if (tail_q == TAIL_W'(TAIL_CYCLES - 1)) begin
                        tail_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tail_d = TAIL_W'(tail_q + 1'b1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign transport = stim_q[2];
    assign bus       = stim_q[1];
    assign train     = stim_q[0];
    assign tc_idx    = idx_q;
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_transit_stim_seq.sv
// Directed bench for transit_stim_seq: STEP_CYCLES=1 and STEP_CYCLES=3 instances
// checked edge by edge against an edge-count reference of the replay.
module tb_transit_stim_seq;

    localparam logic [17:0] TBL = 18'h3B294;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic        hold = 1'b0;
    logic        hold3 = 1'b0;
    logic [17:0] tc_table = TBL;

    logic       t1, b1, tr1, busy1, done1;
    logic [2:0] idx1;
    logic [1:0] ph1;
    logic       t3, b3, tr3, busy3, done3;
    logic [2:0] idx3;
    logic [1:0] ph3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    transit_stim_seq #(.NUM_TC(6), .STEP_CYCLES(1), .TAIL_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .tc_table(tc_table),
        .transport(t1), .bus(b1), .train(tr1), .tc_idx(idx1), .phase(ph1),
        .busy(busy1), .done(done1)
    );

    transit_stim_seq #(.NUM_TC(6), .STEP_CYCLES(3), .TAIL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .hold(hold3), .tc_table(tc_table),
        .transport(t3), .bus(b3), .train(tr3), .tc_idx(idx3), .phase(ph3),
        .busy(busy3), .done(done3)
    );

    wire [9:0] obs1 = {busy1, done1, ph1, idx1, t1, b1, tr1};
    wire [9:0] obs3 = {busy3, done3, ph3, idx3, t3, b3, tr3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {busy,done,phase,idx,T,B,Tr} after c effective edges past the start edge
    function automatic logic [9:0] model(input logic [17:0] tbl, input int c, input int step);
        int u, k, p, last_c;
        logic [2:0] s;
        logic [2:0] idx;
        logic [1:0] ph;
        logic bz, dn;
        s = 3'b000;
        u = c / step;
        if (u > 18) u = 18;
        for (int i = 0; i < u; i++) begin
            k = i / 3;
            p = i % 3;
            s[2-p] = tbl[3*k + 2 - p];
        end
        idx = (u == 18) ? 3'd5 : 3'(u / 3);
        ph  = (u == 18) ? 2'd2 : 2'(u % 3);
        last_c = 18 * step + 3;
        bz = (c < last_c);
        dn = (c == last_c);
        return {bz, dn, ph, idx, s};
    endfunction

    // One STEP_CYCLES=1 run with optional hold window, mid-run start and table clobber
    task automatic run1(input string tag, input int hold_lo, input int hold_hi,
                        input bit mid_start, input int done_edge);
        int c;
        c = 0;
        tc_table = TBL;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start"}, 32'(obs1), 32'(model(TBL, 0, 1)));
        for (int e = 1; e <= 30; e++) begin
            hold = (e >= hold_lo && e <= hold_hi);
            if (mid_start && e == 2) tc_table = 18'h0;
            start = (mid_start && e == 3);
            tick();
            if (!hold) c++;
            chk({tag, "_edge"}, 32'(obs1), 32'(model(TBL, c, 1)));
            if (e == done_edge) chk({tag, "_done_edge"}, 32'({done1, busy1}), 32'(2'b10));
            if (e == done_edge + 1) chk({tag, "_done_drop"}, 32'(done1), 32'(0));
        end
        hold = 1'b0;
        start = 1'b0;
        tc_table = TBL;
    endtask

    initial begin
        int c;

        // Reset state
        tick();
        tick();
        chk("reset_vals", 32'(obs1), 32'(0));
        rst = 1'b0;
        tick();
        tick();
        chk("idle_after_reset", 32'(obs1), 32'(0));
        chk("idle_after_reset3", 32'(obs3), 32'(0));

        // Default run with hand-computed spot values
        tc_table = TBL;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 23; e++) begin
            tick();
            chk("dflt_edge", 32'(obs1), 32'(model(TBL, e, 1)));
            if (e == 1)  chk("dflt_e1_transport", 32'(t1), 32'(1));
            if (e == 4)  chk("dflt_e4_transport", 32'(t1), 32'(0));
            if (e == 5)  chk("dflt_e5_bus", 32'(b1), 32'(1));
            if (e == 12) chk("dflt_e12_train", 32'(tr1), 32'(1));
            if (e == 16) chk("dflt_e16_transport", 32'(t1), 32'(1));
            if (e == 18) chk("dflt_e18_all", 32'({t1, b1, tr1}), 32'(3'b111));
            if (e == 21) chk("dflt_e21_done", 32'({done1, busy1}), 32'(2'b10));
            if (e == 22) chk("dflt_e22_done", 32'(done1), 32'(0));
        end

        // Hold edges 5-9: sequence shifts by 5, done at 26
        run1("hold", 5, 9, 1'b0, 26);

        // Start during run and table cleared at edge 2: no effect
        run1("midstart", 0, -1, 1'b1, 21);

        // Back-to-back: start sampled in done cycle is accepted
        tc_table = TBL;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 21; e++) tick();
        chk("b2b_done", 32'(done1), 32'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_restart", 32'(obs1), 32'(model(TBL, 0, 1)));
        for (int e = 1; e <= 22; e++) tick();
        chk("b2b_idle", 32'(busy1), 32'(0));

        // Asynchronous reset mid-run, restart at edge 12
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        chk("pre_reset_e9", 32'(obs1), 32'(model(TBL, 9, 1)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_now", 32'(obs1), 32'(0));
        tick();
        chk("reset_e10", 32'(obs1), 32'(0));
        rst = 1'b0;
        tick();
        chk("reset_e11", 32'(obs1), 32'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_e12", 32'(obs1), 32'(model(TBL, 0, 1)));
        c = 0;
        for (int e = 13; e <= 35; e++) begin
            tick();
            c++;
            chk("restart_edge", 32'(obs1), 32'(model(TBL, c, 1)));
            if (e == 13) chk("restart_e13_transport", 32'(t1), 32'(1));
            if (e == 33) chk("restart_e33_done", 32'(done1), 32'(1));
        end

        // STEP_CYCLES=3: updates every 3 edges, done at 57
        tc_table = TBL;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            chk("step3_edge", 32'(obs3), 32'(model(TBL, e, 3)));
            if (e == 3)  chk("step3_e3_transport", 32'(t3), 32'(1));
            if (e == 57) chk("step3_e57_done", 32'({done3, busy3}), 32'(2'b10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/transit_stim_seq.md
Name: transit_stim_seq

Overview:
- Synthesizable stimulus sequencer that sits directly upstream of the transport/bus/train assertion checker and drives its three inputs.
- Replays a programmable table of NUM_TC testcases. Each testcase updates transport, then bus, then train, one signal per step of STEP_CYCLES clocks.
- After a tail of idle cycles, it signals completion with a start/busy/done handshake.

Parameters:
- NUM_TC, 6, number of testcases in the table (>=1).
- STEP_CYCLES, 1, clocks between successive signal updates (>=1).
- TAIL_CYCLES, 3, clocks after the last update before done (>=1).
- IDX_W, $clog2(NUM_TC) (min 1), width of tc_idx.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- hold  in  1  freeze sequencing while high.
- tc_table  in  3*NUM_TC  testcase k occupies bits [3k+2:3k] = {transport, bus, train}.
- transport  out  1  stimulus to checker.
- bus  out  1  stimulus to checker.
- train  out  1  stimulus to checker.
- tc_idx  out  IDX_W  index of the current testcase.
- phase  out  2  next signal to update: 0=transport, 1=bus, 2=train.
- busy  out  1  high in RUN and TAIL.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate, including mid-run):
  - FSM goes to IDLE.
  - transport, bus, train, tc_idx, phase, busy, done all go to 0.
  - Internal step counter, tail counter and table copy are cleared.
- FSM states: IDLE, RUN, TAIL.
- IDLE:
  - start=1 at an edge: copy tc_table into an internal register, clear the three outputs to 0, set tc_idx=0, phase=0, step count=0, busy=1, then enter RUN.
  - start=0: remain in IDLE with outputs held.
- RUN, with hold=0 at an edge:
  - If the step count equals STEP_CYCLES-1: drive the signal selected by phase to its table bit for tc_idx, reset the step count to 0, and advance phase.
  - Phase wraps 2->0 with tc_idx+1.
  - If the update is phase 2 of tc_idx=NUM_TC-1: enter TAIL with the tail count at 0; tc_idx and phase hold their final values.
  - Otherwise: increment the step count.
  - Consequence: the first update appears STEP_CYCLES edges after the start edge, and updates are exactly STEP_CYCLES apart.
- TAIL, with hold=0:
  - Increment the tail count each edge.
  - At the edge where it would reach TAIL_CYCLES: enter IDLE with busy=0 and done=1 for exactly one cycle.
  - Outputs keep their final values.
- hold=1 in RUN/TAIL: freeze all counters, phase and tc_idx, and keep outputs stable. hold is ignored in IDLE.
- start while busy is ignored.
- tc_table changes after the start edge have no effect on the current run.
- Back-to-back runs: start sampled in the done=1 cycle is accepted at the next edge.
- Only one output bit changes per update edge. No combinational path from inputs to outputs.

Test Plan:
- Reset check: assert rst mid-cycle -> all outputs 0 immediately without a clock edge, and they stay 0 until start.
- Default run with tc_table=18'h3B294 and start at edge 0. Required values:
  - edge1: transport=1.
  - edge4: transport=0.
  - edge5: bus=1.
  - edge12: train=1.
  - edge16: transport=1.
  - edge18: train=1, so {transport,bus,train}=111.
  - edge21: done=1, busy=0.
  - edge22: done=0.
- STEP_CYCLES=3, same table -> updates at edges 3, 6, 9, … 54; done at edge 57; outputs stable between updates.
- Hold during RUN: hold=1 for edges 5-9 -> no output, tc_idx or phase change during those edges; the whole sequence shifts by exactly 5 cycles; done at edge 26.
- Start at edge 3 mid-run, and tc_table changed to 0 at edge 2 -> no restart, identical waveform to the default run.
- Reset at edge 10 mid-run, start again at edge 12 -> outputs 0 from reset; fresh run, first update at edge 13; done at edge 33.
